// File: rtl/sat_dequant_pipe.sv
// Receive-side dequantizer: signed code -> arithmetic left shift -> signed bias add -> re-saturate.
// Two-stage valid/ready pipeline with a saturating counter of rail (source-clipped) codes.
module sat_dequant_pipe #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 9,
  parameter int SHIFT = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [OUT_W-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_code,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  input  logic                    clip_clr,
  output logic [CNT_W-1:0]        clip_cnt
);

  localparam logic signed [IN_W-1:0]  CODE_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0]  CODE_MIN = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic signed [OUT_W+1:0] SUM_MAX  = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W+1:0] SUM_MIN  = {3'b111, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;

  // Sign-extend to OUT_W+1 bits before shifting so no code value loses bits.
  function automatic logic signed [OUT_W:0] reconstruct(input logic signed [IN_W-1:0] code);
    logic signed [OUT_W:0] ext;
    ext = {{(OUT_W+1-IN_W){code[IN_W-1]}}, code};
    return ext <<< SHIFT;
  endfunction

  // Returns {clamped, sample}.
  function automatic logic [OUT_W:0] saturate(input logic signed [OUT_W+1:0] sum);
    if (sum > SUM_MAX)      return {1'b1, OUT_MAX};
    else if (sum < SUM_MIN) return {1'b1, OUT_MIN};
    else                    return {1'b0, sum[OUT_W-1:0]};
  endfunction

  logic                    vld_p1, vld_p2;
  logic signed [OUT_W:0]   x_p0, x_p1;
  logic signed [OUT_W+1:0] sum_p1;
  logic [OUT_W:0]          res_p1;
  logic signed [OUT_W-1:0] data_p2;
  logic                    sat_p2;
  logic                    en1, en2, accept, rail;

  assign en2      = ~vld_p2 | out_ready;
  assign en1      = ~vld_p1 | en2;
  assign in_ready = en1;
  assign accept   = in_valid & en1;
  assign rail     = (in_code == CODE_MAX) || (in_code == CODE_MIN);

  assign x_p0   = reconstruct(in_code);
  assign sum_p1 = {x_p1[OUT_W], x_p1} + {{2{bias[OUT_W-1]}}, bias};
  assign res_p1 = saturate(sum_p1);

  // Stage 1: capture shifted code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      x_p1   <= '0;
    end else if (en1) begin
      vld_p1 <= in_valid;
      if (in_valid) x_p1 <= x_p0;
    end
  end

  // Stage 2: bias add and clamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sat_p2  <= 1'b0;
    end else if (en2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) {sat_p2, data_p2} <= res_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     clip_cnt <= '0;
    else if (clip_clr)                              clip_cnt <= '0;
    else if (accept && rail && clip_cnt != CNT_MAX) clip_cnt <= clip_cnt + 1'b1;
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_sat   = sat_p2;

endmodule

// File: tb/tb_sat_dequant_pipe.sv
// Bench for sat_dequant_pipe: directed scenarios plus randomized valid/ready traffic
// checked against an integer-arithmetic reference of shift, bias add and clamp.
module tb_sat_dequant_pipe;
  localparam int IN_W  = 5;
  localparam int OUT_W = 9;
  localparam int SHIFT = 2;
  localparam int CNT_W = 8;
  localparam int OMAX  = (1 << (OUT_W-1)) - 1;
  localparam int OMIN  = -(1 << (OUT_W-1));
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic signed [OUT_W-1:0] bias;
  logic                    in_valid, in_ready;
  logic signed [IN_W-1:0]  in_code;
  logic                    out_valid, out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;
  logic                    clip_clr;
  logic [CNT_W-1:0]        clip_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int o_acc, o_rdy, o_ov, o_fire, o_od, o_os;
  int exp_d[$];
  int exp_s[$];
  int exp_c[$];

  sat_dequant_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .clip_clr(clip_clr), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_data(int code, int b);
    int r;
    r = code * (1 << SHIFT) + b;
    if (r > OMAX) r = OMAX;
    else if (r < OMIN) r = OMIN;
    return r;
  endfunction

  function automatic int ref_sat(int code, int b);
    int r;
    r = code * (1 << SHIFT) + b;
    return (r > OMAX || r < OMIN) ? 1 : 0;
  endfunction

  // Drive one cycle (called at posedge+1), observe at negedge, return at next posedge+1.
  task automatic cycle(input int v, input int code, input int ordy);
    in_valid  = (v != 0);
    in_code   = IN_W'(code);
    out_ready = (ordy != 0);
    @(negedge clk);
    o_rdy  = int'(in_ready);
    o_acc  = (v != 0 && in_ready) ? 1 : 0;
    o_ov   = int'(out_valid);
    o_fire = (out_valid && ordy != 0) ? 1 : 0;
    o_od   = int'(out_data);
    o_os   = int'(out_sat);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bias = '0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clip_clr = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%b want=0", out_sat); end
    checks++; if (clip_cnt !== '0) begin errors++; $display("FAIL reset_clip_cnt got=%0d want=0", clip_cnt); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int codes[4] = '{15, -16, 0, -1};
    int want[4]  = '{60, -64, 0, -4};
    int idx = 0, nout = 0, cur;
    bias = '0;
    for (int k = 0; k < 10; k++) begin
      cur = cyc;
      cycle(idx < 4 ? 1 : 0, idx < 4 ? codes[idx] : 0, 1);
      if (o_fire != 0) begin
        checks++;
        if (nout >= 4 || o_od != want[nout] || o_os != 0 || cur - exp_c[0] != 2) begin
          errors++;
          $display("FAIL basic_out[%0d] got data=%0d sat=%0d lat=%0d want data=%0d sat=0 lat=2",
                   nout, o_od, o_os, cur - exp_c[0], nout < 4 ? want[nout] : 0);
        end
        void'(exp_c.pop_front());
        nout++;
      end
      if (o_acc != 0) begin exp_c.push_back(cur); idx++; end
    end
    checks++; if (nout != 4) begin errors++; $display("FAIL basic_count got=%0d want=4", nout); end
    checks++; if (clip_cnt !== 8'd2) begin errors++; $display("FAIL basic_clip_cnt got=%0d want=2", clip_cnt); end
    exp_c.delete();
  endtask

  task automatic test_bias();
    int bs[3] = '{200, -200, 100};
    int cs[3] = '{15, -16, 3};
    int ds[3] = '{255, -256, 112};
    int ss[3] = '{1, 1, 0};
    int got;
    for (int i = 0; i < 3; i++) begin
      bias = OUT_W'(bs[i]);
      got = 0;
      for (int k = 0; k < 6 && got == 0; k++) begin
        cycle(k == 0 ? 1 : 0, cs[i], 1);
        if (o_fire != 0) begin
          got = 1;
          checks++;
          if (o_od != ds[i] || o_os != ss[i]) begin
            errors++;
            $display("FAIL bias_case%0d got data=%0d sat=%0d want data=%0d sat=%0d", i, o_od, o_os, ds[i], ss[i]);
          end
        end
      end
      if (got == 0) begin checks++; errors++; $display("FAIL bias_case%0d got no output want one beat", i); end
    end
    bias = '0;
  endtask

  task automatic test_backpressure();
    int codes[3] = '{1, 2, 3};
    int fire_k[$];
    int idx = 0;
    bias = '0;
    exp_d.delete();
    for (int k = 0; k < 10; k++) begin
      cycle(idx < 3 ? 1 : 0, idx < 3 ? codes[idx] : 0, k >= 4 ? 1 : 0);
      if (k == 2 || k == 3) begin
        checks++;
        if (o_rdy != 0 || o_ov != 1 || o_od != 4) begin
          errors++;
          $display("FAIL stall_k%0d got in_ready=%0d out_valid=%0d data=%0d want 0 1 4", k, o_rdy, o_ov, o_od);
        end
      end
      if (k == 3) begin
        checks++; if (idx != 2) begin errors++; $display("FAIL stall_accepted got=%0d want=2", idx); end
      end
      if (o_fire != 0) begin
        checks++;
        if (exp_d.size() == 0 || o_od != exp_d[0]) begin
          errors++;
          $display("FAIL bp_order got=%0d want=%0d", o_od, exp_d.size() ? exp_d[0] : 9999);
        end
        if (exp_d.size() != 0) void'(exp_d.pop_front());
        fire_k.push_back(k);
      end
      if (o_acc != 0) begin exp_d.push_back(ref_data(codes[idx], 0)); idx++; end
    end
    checks++;
    if (fire_k.size() != 3 || fire_k[0] != 4 || fire_k[1] != 5 || fire_k[2] != 6) begin
      errors++;
      $display("FAIL bp_timing got beats=%0d first=%0d last=%0d want 3 beats at cycles 4..6",
               fire_k.size(), fire_k.size() ? fire_k[0] : -1, fire_k.size() ? fire_k[fire_k.size()-1] : -1);
    end
    exp_d.delete();
  endtask

  task automatic test_random();
    int b, n_acc, pend, v, ordy, bnd;
    for (int r = 0; r < 2; r++) begin
      b = int'($urandom_range(0, 511)) - 256;
      bias = OUT_W'(b);
      exp_d.delete(); exp_s.delete();
      n_acc = 0;
      pend = int'($urandom_range(0, 31)) - 16;
      for (bnd = 0; bnd < 8000 && (n_acc < 500 || exp_d.size() > 0); bnd++) begin
        v    = (n_acc < 500 && $urandom_range(0, 3) != 0) ? 1 : 0;
        ordy = ($urandom_range(0, 3) != 0) ? 1 : 0;
        cycle(v, pend, ordy);
        if (o_fire != 0) begin
          checks++;
          if (exp_d.size() == 0) begin
            errors++;
            $display("FAIL rand_extra_beat got=%0d want none", o_od);
          end else begin
            if (o_od != exp_d[0] || o_os != exp_s[0]) begin
              errors++;
              $display("FAIL rand_beat got data=%0d sat=%0d want data=%0d sat=%0d bias=%0d",
                       o_od, o_os, exp_d[0], exp_s[0], b);
            end
            void'(exp_d.pop_front());
            void'(exp_s.pop_front());
          end
        end
        if (o_acc != 0) begin
          exp_d.push_back(ref_data(pend, b));
          exp_s.push_back(ref_sat(pend, b));
          n_acc++;
          pend = int'($urandom_range(0, 31)) - 16;
        end
      end
      checks++;
      if (n_acc != 500 || exp_d.size() != 0) begin
        errors++;
        $display("FAIL rand_drain got accepted=%0d pending=%0d want 500 0", n_acc, exp_d.size());
      end
    end
    bias = '0;
  endtask

  task automatic test_clip();
    int acc_n = 0;
    clip_clr = 1'b1;
    cycle(0, 0, 1);
    clip_clr = 1'b0;
    checks++; if (clip_cnt !== '0) begin errors++; $display("FAIL clip_clear got=%0d want=0", clip_cnt); end
    for (int k = 0; k < 300; k++) begin
      cycle(1, (k % 2) ? 15 : -16, 1);
      acc_n += o_acc;
    end
    checks++;
    if (int'(clip_cnt) != (acc_n > CMAX ? CMAX : acc_n) || acc_n != 300) begin
      errors++;
      $display("FAIL clip_saturate got cnt=%0d accepted=%0d want cnt=%0d accepted=300", clip_cnt, acc_n, CMAX);
    end
    clip_clr = 1'b1;
    cycle(1, 15, 1);
    clip_clr = 1'b0;
    checks++;
    if (clip_cnt !== '0 || o_acc != 1) begin
      errors++;
      $display("FAIL clip_clr_wins got cnt=%0d acc=%0d want cnt=0 acc=1", clip_cnt, o_acc);
    end
    cycle(1, -16, 1);
    checks++; if (clip_cnt !== 8'd1) begin errors++; $display("FAIL clip_after_clr got=%0d want=1", clip_cnt); end
    cycle(1, 7, 1);
    checks++; if (clip_cnt !== 8'd1) begin errors++; $display("FAIL clip_nonrail got=%0d want=1", clip_cnt); end
    repeat (3) cycle(0, 0, 1);
  endtask

  task automatic test_reset_midflight();
    int seen, got;
    bias = '0;
    cycle(1, 5, 0);
    cycle(1, 6, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got out_valid=%b want=1", out_valid); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || clip_cnt !== '0) begin
      errors++;
      $display("FAIL mid_async_reset got out_valid=%b in_ready=%b clip=%0d want 0 1 0", out_valid, in_ready, clip_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 1);
      seen += o_ov;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_stale_beat got beats=%0d want=0", seen); end
    got = 0;
    for (int k = 0; k < 6 && got == 0; k++) begin
      cycle(k == 0 ? 1 : 0, -3, 1);
      if (o_fire != 0) begin
        got = 1;
        checks++;
        if (o_od != -12 || o_os != 0) begin
          errors++;
          $display("FAIL mid_restart got data=%0d sat=%0d want -12 0", o_od, o_os);
        end
      end
    end
    if (got == 0) begin checks++; errors++; $display("FAIL mid_restart got no output want one beat"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias();
    test_backpressure();
    test_random();
    test_clip();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
